// File: rtl/des13x40_pkg.sv
// Shared widths and types for the 13-to-40 bit gearbox deserializer.
package des13x40_pkg;

  localparam int unsigned IN_W  = 13;
  localparam int unsigned OUT_W = 40;
  localparam int unsigned BUF_W = 52;  // 39 residual bits plus one new word
  localparam int unsigned CNT_W = 6;   // holds fill counts up to 52

  typedef logic [BUF_W-1:0] bitbuf_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // True when the appended fill count holds at least one full output word.
  function automatic logic wrap_due(input cnt_t new_cnt);
    return new_cnt >= CNT_W'(OUT_W);
  endfunction

endpackage

// File: rtl/des13x40_shift.sv
// Variable-position append network: places the new word directly behind the
// residual bits of the left-justified bit buffer.
module des13x40_shift
  import des13x40_pkg::*;
(
  input  bitbuf_t              bit_buf,
  input  cnt_t                 cnt,
  input  logic [IN_W-1:0]      din,
  output bitbuf_t              appended_c
);

  bitbuf_t din_left;

  // Left-justify the new word, then slide it right past the residual bits.
  // Bits below the fill count are kept zero, so a plain OR merges the two.
  always_comb begin
    din_left   = {din, {(BUF_W-IN_W){1'b0}}};
    appended_c = bit_buf | (din_left >> cnt);
  end

endmodule

// File: rtl/des13x40.sv
// Gearbox deserializer: packs a continuous 13-bit stream (MSB-first) into
// 40-bit words, with a one-cycle write strobe per emitted word.
module des13x40
  import des13x40_pkg::*;
(
  input  logic              Cin,
  input  logic              Rst_n,
  input  logic [IN_W-1:0]   Din,
  output logic [OUT_W-1:0]  Dout,
  output logic              WE
);

  bitbuf_t bit_buf;
  bitbuf_t appended_c;
  cnt_t    cnt;
  cnt_t    new_cnt_c;

  des13x40_shift u_shift (
    .bit_buf    (bit_buf),
    .cnt        (cnt),
    .din        (Din),
    .appended_c (appended_c)
  );

  // Fill count after appending the current word.
  always_comb begin
    new_cnt_c = cnt + CNT_W'(IN_W);
  end

  // Buffer/count update and output extraction; oldest 40 bits leave when due.
  always_ff @(posedge Cin or negedge Rst_n) begin
    if (!Rst_n) begin
      bit_buf <= '0;
      cnt     <= '0;
      Dout    <= '0;
      WE      <= 1'b0;
    end else if (wrap_due(new_cnt_c)) begin
      Dout    <= appended_c[BUF_W-1 -: OUT_W];
      bit_buf <= {appended_c[BUF_W-OUT_W-1:0], {OUT_W{1'b0}}};
      cnt     <= new_cnt_c - CNT_W'(OUT_W);
      WE      <= 1'b1;
    end else begin
      bit_buf <= appended_c;
      cnt     <= new_cnt_c;
      WE      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_des13x40.sv
// Self-checking bench for des13x40 against a bit-queue reference model.
module tb_des13x40;

  logic        Cin;
  logic        Rst_n;
  logic [12:0] Din;
  logic [39:0] Dout;
  logic        WE;

  int checks   = 0;
  int failures = 0;

  // Reference model: a FIFO of stream bits, oldest first.
  bit          q[$];
  logic [39:0] exp_dout;
  logic        exp_we;

  des13x40 dut (
    .Cin   (Cin),
    .Rst_n (Rst_n),
    .Din   (Din),
    .Dout  (Dout),
    .WE    (WE)
  );

  initial Cin = 1'b0;
  always #5 Cin = ~Cin;

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One word per clock; starts and ends just after a falling edge.
  task automatic step(input logic [12:0] d, input string tag);
    Din = d;
    @(posedge Cin);
    #1;
    for (int i = 12; i >= 0; i--) q.push_back(d[i]);
    if (q.size() >= 40) begin
      exp_we = 1'b1;
      for (int i = 39; i >= 0; i--) exp_dout[i] = q.pop_front();
    end else begin
      exp_we = 1'b0;
    end
    chk({tag, "_we"}, 64'(WE), 64'(exp_we));
    chk({tag, "_dout"}, 64'(Dout), 64'(exp_dout));
    @(negedge Cin);
  endtask

  task automatic model_clear();
    q.delete();
    exp_dout = '0;
    exp_we   = 1'b0;
  endtask

  // Reset for two clocks with random input, released on a falling edge.
  task automatic do_reset();
    Rst_n = 1'b0;
    model_clear();
    for (int i = 0; i < 2; i++) begin
      Din = 13'($urandom);
      @(posedge Cin);
      #1;
      chk("rst_hold_we", 64'(WE), 64'd0);
      chk("rst_hold_dout", 64'(Dout), 64'd0);
      @(negedge Cin);
    end
    Rst_n = 1'b1;
  endtask

  function automatic logic cadence_we(input int k);
    int kk;
    kk = ((k - 1) % 40) + 1;
    return (kk >= 4) && ((kk - 4) % 3 == 0);
  endfunction

  initial begin
    logic [12:0]  pat;
    logic [12:0]  wa, wb, wc, wd;
    logic [519:0] got_cat, exp_cat;
    int           pulses, words;
    logic         prev_we;

    Rst_n = 1'b0;
    Din   = '0;
    model_clear();

    // 1. Held reset with toggling clock and random data.
    for (int i = 0; i < 5; i++) begin
      Din = 13'($urandom);
      @(posedge Cin);
      #1;
      chk("t1_we", 64'(WE), 64'd0);
      chk("t1_dout", 64'(Dout), 64'd0);
    end
    @(negedge Cin);
    Rst_n = 1'b1;

    // 2. Constant pattern: first strobe on edge 4 with a known word, next on edge 7.
    pat = 13'b1100110011001;
    for (int k = 1; k <= 4; k++) step(pat, "t2");
    chk("t2_first_dout", 64'(Dout), 64'h00CCCE667333);
    chk("t2_first_we", 64'(WE), 64'd1);
    // Asynchronous reset between edges clears outputs at once.
    Rst_n = 1'b0;
    #1;
    chk("t1_async_we", 64'(WE), 64'd0);
    chk("t1_async_dout", 64'(Dout), 64'd0);
    model_clear();
    @(negedge Cin);
    Rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step(pat, "t2b");
      chk("t2_cadence", 64'(WE), 64'(cadence_we(k)));
    end

    // 3. Random data: cadence, pulse count, no back-to-back strobes.
    do_reset();
    pulses  = 0;
    prev_we = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      step(13'($urandom), "t3");
      chk("t3_cadence", 64'(WE), 64'(cadence_we(k)));
      chk("t3_b2b", 64'(WE & prev_we), 64'd0);
      if (WE) pulses++;
      prev_we = WE;
    end
    chk("t3_pulses", 64'(pulses), 64'd26);

    // 4. Incrementing words: concatenated outputs equal concatenated inputs.
    do_reset();
    got_cat = '0;
    exp_cat = '0;
    words   = 0;
    for (int k = 0; k < 40; k++) begin
      step(13'(k), "t4");
      exp_cat = {exp_cat[506:0], 13'(k)};
      if (WE) begin
        got_cat = {got_cat[479:0], Dout};
        words++;
      end
    end
    chk("t4_words", 64'(words), 64'd13);
    for (int s = 0; s < 520; s += 40)
      chk("t4_concat", 64'(got_cat[s +: 40]), 64'(exp_cat[s +: 40]));

    // 5. Mid-stream reset discards residual bits.
    do_reset();
    for (int k = 0; k < 5; k++) step(13'($urandom), "t5pre");
    Rst_n = 1'b0;
    #1;
    model_clear();
    @(negedge Cin);
    Rst_n = 1'b1;
    wa = 13'($urandom);
    wb = 13'($urandom);
    wc = 13'($urandom);
    wd = 13'($urandom);
    step(wa, "t5");
    step(wb, "t5");
    step(wc, "t5");
    step(wd, "t5");
    chk("t5_we", 64'(WE), 64'd1);
    chk("t5_dout", 64'(Dout), 64'({wa, wb, wc, wd[12]}));

    // 6. All-ones then all-zeros.
    do_reset();
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      step(13'h1FFF, "t6a");
      if (WE) begin
        pulses++;
        chk("t6_ones", 64'(Dout), 64'h00FFFFFFFFFF);
      end
    end
    chk("t6_ones_pulses", 64'(pulses), 64'd13);
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      step(13'h0000, "t6b");
      chk("t6_zero_cadence", 64'(WE), 64'(cadence_we(k)));
      if (WE) begin
        pulses++;
        chk("t6_zeros", 64'(Dout), 64'd0);
      end
    end
    chk("t6_zero_pulses", 64'(pulses), 64'd13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
